// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic, plus iterative shift-add multiply
// and restoring divide/remainder taking DATA_WIDTH cycles each.
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OPRN_WIDTH-1:0] oprn,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  zero,
    output logic                  err,
    output logic                  busy,
    output logic                  done
);

    localparam logic [OPRN_WIDTH-1:0] OP_ADD  = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OP_SUB  = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OP_MUL  = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OP_SRL  = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OP_SLL  = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OP_AND  = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OP_OR   = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OP_NOR  = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OP_SLTU = OPRN_WIDTH'(9);
    localparam logic [OPRN_WIDTH-1:0] OP_DIV  = OPRN_WIDTH'(10);
    localparam logic [OPRN_WIDTH-1:0] OP_REM  = OPRN_WIDTH'(11);
    localparam logic [OPRN_WIDTH-1:0] OP_SLT  = OPRN_WIDTH'(12);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] out_reg, out_next;
    logic                  zero_reg, zero_next;
    logic                  err_reg, err_next;
    logic                  done_reg, done_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic [DATA_WIDTH-1:0] acc_reg, acc_next;
    logic [DATA_WIDTH-1:0] mcand_reg, mcand_next;
    logic [DATA_WIDTH-1:0] mplier_reg, mplier_next;
    logic [DATA_WIDTH-1:0] rem_reg, rem_next;
    logic [DATA_WIDTH-1:0] quo_reg, quo_next;
    logic [DATA_WIDTH-1:0] divisor_reg, divisor_next;
    logic                  is_rem_reg, is_rem_next;
    logic                  dbz_reg, dbz_next;

    logic [DATA_WIDTH-1:0] sc_result;
    logic                  sc_err;
    logic [DATA_WIDTH-1:0] mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH:0]   div_diff;
    logic                  div_fits;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quo_step;
    logic                  last_iter;

    // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
    assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // One restoring-division step: bring in the next dividend bit, subtract if it fits.
    assign div_shift = {rem_reg, quo_reg[DATA_WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, divisor_reg};
    assign div_fits  = ~div_diff[DATA_WIDTH];
    assign rem_step  = div_fits ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    assign quo_step  = {quo_reg[DATA_WIDTH-2:0], div_fits};
    assign last_iter = (count_reg == CNT_WIDTH'(1));

    always_comb begin
        sc_result = '0;
        sc_err    = 1'b0;
        case (oprn)
            OP_ADD:  sc_result = op1 + op2;
            OP_SUB:  sc_result = op1 - op2;
            OP_SRL:  sc_result = (op2 >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (op1 >> op2);
            OP_SLL:  sc_result = (op2 >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (op1 << op2);
            OP_AND:  sc_result = op1 & op2;
            OP_OR:   sc_result = op1 | op2;
            OP_NOR:  sc_result = ~(op1 | op2);
            OP_SLTU: sc_result = DATA_WIDTH'(op1 < op2);
            OP_SLT:  sc_result = DATA_WIDTH'($signed(op1) < $signed(op2));
            OP_MUL, OP_DIV, OP_REM: sc_result = '0;
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        out_next     = out_reg;
        zero_next    = zero_reg;
        err_next     = err_reg;
        done_next    = 1'b0;
        count_next   = count_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        divisor_next = divisor_reg;
        is_rem_next  = is_rem_reg;
        dbz_next     = dbz_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (oprn == OP_MUL) begin
                        state_next  = S_MUL;
                        count_next  = CNT_WIDTH'(DATA_WIDTH);
                        acc_next    = '0;
                        mcand_next  = op1;
                        mplier_next = op2;
                    end else if (oprn == OP_DIV || oprn == OP_REM) begin
                        state_next   = S_DIV;
                        count_next   = CNT_WIDTH'(DATA_WIDTH);
                        rem_next     = '0;
                        quo_next     = op1;
                        divisor_next = op2;
                        is_rem_next  = (oprn == OP_REM);
                        dbz_next     = (op2 == '0);
                    end else begin
                        out_next  = sc_result;
                        zero_next = (sc_result == '0);
                        err_next  = sc_err;
                        done_next = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_next    = mul_sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                count_next  = count_reg - CNT_WIDTH'(1);
                if (last_iter) begin
                    state_next = S_IDLE;
                    out_next   = mul_sum;
                    zero_next  = (mul_sum == '0);
                    err_next   = 1'b0;
                    done_next  = 1'b1;
                end
            end
            S_DIV: begin
                rem_next   = rem_step;
                quo_next   = quo_step;
                count_next = count_reg - CNT_WIDTH'(1);
                if (last_iter) begin
                    // A zero divisor naturally yields all-ones quotient and remainder = dividend.
                    state_next = S_IDLE;
                    out_next   = is_rem_reg ? rem_step : quo_step;
                    zero_next  = ((is_rem_reg ? rem_step : quo_step) == '0);
                    err_next   = dbz_reg;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            out_reg     <= '0;
            zero_reg    <= 1'b1;
            err_reg     <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            is_rem_reg  <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            out_reg     <= out_next;
            zero_reg    <= zero_next;
            err_reg     <= err_next;
            done_reg    <= done_next;
            count_reg   <= count_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            divisor_reg <= divisor_next;
            is_rem_reg  <= is_rem_next;
            dbz_reg     <= dbz_next;
        end
    end

    assign out  = out_reg;
    assign zero = zero_reg;
    assign err  = err_reg;
    assign done = done_reg;
    assign busy = (state_reg != S_IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results are queued at issue time and
// checked (value, flags, latency) whenever DONE pulses.
module tb_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   oprn = '0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [W-1:0] out;
    logic         zero, err, busy, done;

    alu_seq #(.DATA_WIDTH(W), .OPRN_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oprn(oprn),
        .op1(op1), .op2(op2), .out(out), .zero(zero), .err(err),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [W-1:0] out;
        logic         err;
        int           due;
        logic [5:0]   op;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
        r = '0;
        e = 1'b0;
        case (op)
            6'h01: r = a + b;
            6'h02: r = a - b;
            6'h03: r = a * b;
            6'h04: r = (b >= W) ? '0 : a >> b;
            6'h05: r = (b >= W) ? '0 : a << b;
            6'h06: r = a & b;
            6'h07: r = a | b;
            6'h08: r = ~(a | b);
            6'h09: r = W'(a < b);
            6'h0A: if (b == 0) begin r = '1; e = 1'b1; end else r = a / b;
            6'h0B: if (b == 0) begin r = a; e = 1'b1; end else r = a % b;
            6'h0C: r = W'($signed(a) < $signed(b));
            default: e = 1'b1;
        endcase
    endfunction

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        model(op, a, b, e.out, e.err);
        e.op  = op;
        e.due = cyc + 1 + ((op == 6'h03 || op == 6'h0A || op == 6'h0B) ? W : 0);
        oprn  = op;
        op1   = a;
        op2   = b;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        oprn  = 6'($urandom);
        op1   = $urandom;
        op2   = $urandom;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", W'(sb.size()), '0);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_has_pending_op", W'(sb.size() != 0), W'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("op%02h_out", e.op), out, e.out);
                chk($sformatf("op%02h_zero", e.op), W'(zero), W'(e.out == '0));
                chk($sformatf("op%02h_err", e.op), W'(err), W'(e.err));
                chk($sformatf("op%02h_latency", e.op), W'(cyc), W'(e.due));
                $display("txn op=%02h out=%h zero=%0d err=%0d at cycle %0d", e.op, out, zero, err, cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bcnt;
        int dn;
        logic [5:0]   rop;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("reset_out", out, '0);
        chk("reset_zero", W'(zero), W'(1));
        chk("reset_err", W'(err), '0);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops
        issue(6'h01, 32'hFFFF_FFFF, 32'h1);
        chk("add_busy", W'(busy), '0);
        drain(10);
        issue(6'h08, 32'h0, 32'h0);            drain(10);
        issue(6'h05, 32'h1, 32'd32);           drain(10);
        issue(6'h04, 32'h8000_0000, 32'd31);   drain(10);
        issue(6'h0C, 32'hFFFF_FFFF, 32'h1);    drain(10);
        issue(6'h09, 32'hFFFF_FFFF, 32'h1);    drain(10);
        issue(6'h02, 32'h0, 32'h1);            drain(10);

        // Multiply with BUSY duration
        issue(6'h03, 32'h0001_0000, 32'h0001_0003);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", W'(bcnt), W'(W));
        drain(10);

        // Divide, remainder, divide-by-zero
        issue(6'h0A, 32'd100, 32'd7);  drain(50);
        issue(6'h0B, 32'd100, 32'd7);  drain(50);
        issue(6'h0A, 32'd5, 32'd0);    drain(50);
        issue(6'h0B, 32'd5, 32'd0);    drain(50);

        // START during BUSY is ignored
        issue(6'h03, 32'd12345, 32'd678);
        repeat (5) @(negedge clk);
        oprn = 6'h01; op1 = 32'h1; op2 = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(50);

        // Back-to-back: new START in the DONE cycle
        issue(6'h03, 32'hDEAD_BEEF, 32'h1234_5678);
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mul_done_seen", W'(done), W'(1));
        issue(6'h01, 32'd5, 32'd6);
        issue(6'h06, 32'hF0F0_F0F0, 32'hFF00_FF00);
        drain(10);

        // Illegal opcode, then a legal op clears ERR
        issue(6'h3F, 32'h1234, 32'h5678);  drain(10);
        issue(6'h07, 32'h0, 32'h0);        drain(10);
        issue(6'h01, 32'h2, 32'h3);        drain(10);

        // Random mix
        for (int i = 0; i < 12; i++) begin
            rop = 6'($urandom_range(0, 13));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            issue(rop, ra, rb);
            drain(60);
        end

        // Reset mid-multiply aborts without a DONE
        oprn = 6'h03; op1 = 32'd7; op2 = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out", out, '0);
        chk("rst_mid_zero", W'(zero), W'(1));
        chk("rst_mid_busy", W'(busy), '0);
        chk("rst_mid_done", W'(done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no_done_after_reset", W'(dn), '0);
        chk("idle_after_reset", W'(busy), '0);

        chk("scoreboard_empty", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
